// File: rtl/doodle_y_physics.sv
// rtl/doodle_y_physics.sv - vertical motion engine for the doodle (ride, fall, swept landing, death)
//
// Purpose: tracks the doodle's bottom row against NUM_PLAT platforms. While riding it follows
//   the ridden platform's top row. While falling it accelerates up to V_MAX per tick and
//   lands on the nearest platform crossed during the tick, so nothing is skipped at speed.
//   Floor and ceiling deaths are sticky until reset.
// Ports:
//   clk, rst      system clock, asynchronous active-low reset
//   tick          gravity strobe; motion only happens on tick cycles
//   terminated    freezes all state while high
//   plat_vpos     packed platform top rows, platform i at [i*POS_W +: POS_W]
//   plat_hpos     packed platform left columns
//   d_x           doodle left column
//   d_y           doodle bottom row
//   vel           downward velocity, 0..V_MAX
//   on_plat       high while riding a platform
//   plat_idx      platform being ridden
//   dead          sticky death flag
module doodle_y_physics #(
  parameter int NUM_PLAT   = 7,
  parameter int POS_W      = 10,
  parameter int SIZE       = 20,
  parameter int PLAT_W     = 75,
  parameter int V_MAX      = 6,
  parameter int SCREEN_H   = 480,
  parameter int CEIL       = 0,
  parameter int START_PLAT = 3,
  localparam int IDX_W     = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      terminated,
  input  logic [NUM_PLAT*POS_W-1:0] plat_vpos,
  input  logic [NUM_PLAT*POS_W-1:0] plat_hpos,
  input  logic [POS_W-1:0]          d_x,
  output logic [POS_W-1:0]          d_y,
  output logic [3:0]                vel,
  output logic                      on_plat,
  output logic [IDX_W-1:0]          plat_idx,
  output logic                      dead
);

  // One extra bit on every sum so comparisons never see wrap-around.
  localparam int W1 = POS_W + 1;

  typedef enum logic [1:0] {S_SPAWN, S_RIDE, S_FALL, S_DEAD} state_t;

  state_t           state, state_nxt;
  logic [POS_W-1:0] d_y_nxt;
  logic [3:0]       vel_nxt;
  logic [IDX_W-1:0] plat_idx_nxt;
  logic             dead_nxt;

  logic [W1-1:0]       vpos_e [NUM_PLAT];
  logic [W1-1:0]       hpos_e [NUM_PLAT];
  logic [NUM_PLAT-1:0] ovl;
  logic [W1-1:0]       dx_e, dy_e, nxt;

  logic [W1-1:0]    ride_v, ride_dy;
  logic             ride_ovl;
  logic             land_found;
  logic [W1-1:0]    land_v;
  logic [IDX_W-1:0] land_i;
  logic [3:0]       vel_inc;

  assign dx_e    = {1'b0, d_x};
  assign dy_e    = {1'b0, d_y};
  assign nxt     = dy_e + W1'(vel);
  assign vel_inc = (vel < 4'(V_MAX)) ? vel + 4'd1 : 4'(V_MAX);

  // Unpack buses and compute horizontal overlap with every platform.
  always_comb begin
    for (int i = 0; i < NUM_PLAT; i++) begin
      vpos_e[i] = {1'b0, plat_vpos[i*POS_W +: POS_W]};
      hpos_e[i] = {1'b0, plat_hpos[i*POS_W +: POS_W]};
      ovl[i]    = (dx_e + W1'(SIZE) > hpos_e[i]) && (dx_e < hpos_e[i] + W1'(PLAT_W));
    end
  end

  // Ridden platform lookup, written as a compare mux so a non-power-of-two
  // NUM_PLAT never indexes past the array.
  always_comb begin
    ride_v   = '0;
    ride_ovl = 1'b0;
    for (int i = 0; i < NUM_PLAT; i++) begin
      if (IDX_W'(i) == plat_idx) begin
        ride_v   = vpos_e[i];
        ride_ovl = ovl[i];
      end
    end
    ride_dy = ride_ovl ? ride_v - W1'(1) : dy_e;
  end

  // Swept landing: a platform is crossed this tick if its top row is below the
  // current bottom row and the doodle would reach the row above it. The nearest
  // (smallest vpos) wins; strict '<' keeps the lowest index on ties.
  always_comb begin
    land_found = 1'b0;
    land_v     = '0;
    land_i     = '0;
    for (int i = 0; i < NUM_PLAT; i++) begin
      if (ovl[i] && (dy_e < vpos_e[i]) && (nxt + W1'(1) >= vpos_e[i])) begin
        if (!land_found || (vpos_e[i] < land_v)) begin
          land_found = 1'b1;
          land_v     = vpos_e[i];
          land_i     = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    d_y_nxt      = d_y;
    vel_nxt      = vel;
    plat_idx_nxt = plat_idx;
    dead_nxt     = dead;
    if (!terminated) begin
      case (state)
        S_SPAWN: begin
          d_y_nxt      = POS_W'(vpos_e[START_PLAT] - W1'(1));
          plat_idx_nxt = IDX_W'(START_PLAT);
          vel_nxt      = 4'd0;
          state_nxt    = S_RIDE;
        end
        S_RIDE: begin
          if (tick) begin
            d_y_nxt = POS_W'(ride_dy);
            if (ride_ovl) begin
              vel_nxt = 4'd0;
            end else begin
              vel_nxt   = 4'd1;
              state_nxt = S_FALL;
            end
            // Top row = d_y - SIZE + 1; rearranged to stay non-negative.
            if (ride_dy + W1'(1) <= W1'(CEIL + SIZE)) begin
              dead_nxt  = 1'b1;
              state_nxt = S_DEAD;
            end
          end
        end
        S_FALL: begin
          if (tick) begin
            if (land_found) begin
              d_y_nxt      = POS_W'(land_v - W1'(1));
              plat_idx_nxt = land_i;
              vel_nxt      = 4'd0;
              state_nxt    = S_RIDE;
            end else if (nxt >= W1'(SCREEN_H)) begin
              dead_nxt  = 1'b1;
              state_nxt = S_DEAD;
            end else begin
              d_y_nxt = POS_W'(nxt);
              vel_nxt = vel_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_SPAWN;
      d_y      <= '0;
      vel      <= '0;
      on_plat  <= 1'b0;
      plat_idx <= '0;
      dead     <= 1'b0;
    end else begin
      state    <= state_nxt;
      d_y      <= d_y_nxt;
      vel      <= vel_nxt;
      on_plat  <= (state_nxt == S_RIDE);
      plat_idx <= plat_idx_nxt;
      dead     <= dead_nxt;
    end
  end

endmodule

// File: tb/tb_doodle_y_physics.sv
// tb/tb_doodle_y_physics.sv - self-checking bench for doodle_y_physics
module tb_doodle_y_physics;
  localparam int NP = 7, PW = 10, SIZE = 20, PLAT_W = 75, V_MAX = 6;
  localparam int SCREEN_H = 480, CEIL = 0, START = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           tick = 1'b0;
  logic           terminated = 1'b0;
  logic [NP*PW-1:0] plat_vpos, plat_hpos;
  logic [PW-1:0]  d_x;
  logic [PW-1:0]  d_y;
  logic [3:0]     vel;
  logic           on_plat;
  logic [2:0]     plat_idx;
  logic           dead;

  doodle_y_physics dut (
    .clk(clk), .rst(rst), .tick(tick), .terminated(terminated),
    .plat_vpos(plat_vpos), .plat_hpos(plat_hpos), .d_x(d_x),
    .d_y(d_y), .vel(vel), .on_plat(on_plat), .plat_idx(plat_idx), .dead(dead)
  );

  always #5 clk = ~clk;

  int vp [NP];
  int hp [NP];
  int n_checks = 0;
  int n_fail = 0;

  // Reference model: mode 0 = waiting to spawn, 1 = riding, 2 = falling, 3 = dead
  int m_mode, m_dy, m_vel, m_idx, m_dead;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit overlaps(input int i);
    return (int'(d_x) + SIZE > hp[i]) && (int'(d_x) < hp[i] + PLAT_W);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_dy = 0; m_vel = 0; m_idx = 0; m_dead = 0;
  endtask

  task automatic model_step();
    int nxt, best;
    if (!rst) begin model_reset(); return; end
    if (terminated) return;
    case (m_mode)
      0: begin
        m_dy = vp[START] - 1; m_idx = START; m_vel = 0; m_mode = 1;
      end
      1: if (tick) begin
        if (overlaps(m_idx)) begin
          m_dy = vp[m_idx] - 1; m_vel = 0;
        end else begin
          m_vel = 1; m_mode = 2;
        end
        if (m_dy - SIZE + 1 <= CEIL) begin m_dead = 1; m_mode = 3; end
      end
      2: if (tick) begin
        nxt = m_dy + m_vel;
        best = -1;
        for (int i = 0; i < NP; i++)
          if (overlaps(i) && m_dy < vp[i] && nxt >= vp[i] - 1)
            if (best < 0 || vp[i] < vp[best]) best = i;
        if (best >= 0) begin
          m_dy = vp[best] - 1; m_idx = best; m_vel = 0; m_mode = 1;
        end else if (nxt >= SCREEN_H) begin
          m_dead = 1; m_mode = 3;
        end else begin
          m_dy = nxt; m_vel = (m_vel + 1 > V_MAX) ? V_MAX : m_vel + 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".d_y"}, int'(d_y), m_dy);
    chk({tag, ".vel"}, int'(vel), m_vel);
    chk({tag, ".on_plat"}, int'(on_plat), (m_mode == 1) ? 1 : 0);
    chk({tag, ".dead"}, int'(dead), m_dead);
    if (m_mode == 1) chk({tag, ".plat_idx"}, int'(plat_idx), m_idx);
  endtask

  task automatic pack();
    for (int i = 0; i < NP; i++) begin
      plat_vpos[i*PW +: PW] = PW'(vp[i]);
      plat_hpos[i*PW +: PW] = PW'(hp[i]);
    end
  endtask

  // Inputs change #1 after an edge; model advances with the inputs the edge will see.
  task automatic step(input bit t);
    tick = t;
    pack();
    model_step();
    @(posedge clk);
    #1;
    check_all("cyc");
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    model_reset();
    chk("async_rst.d_y", int'(d_y), 0);
    chk("async_rst.on_plat", int'(on_plat), 0);
    chk("async_rst.plat_idx", int'(plat_idx), 0);
    check_all("rst");
    step(1'b1);
    rst = 1'b1;
  endtask

  initial begin
    int exp_dy, exp_v, r;
    for (int i = 0; i < NP; i++) begin vp[i] = 400; hp[i] = 1000; end
    d_x = 10'd110;
    vp[3] = 300; hp[3] = 100;
    pack();
    @(posedge clk); #1;
    do_reset();

    // Spawn on START platform without a tick
    step(1'b0);
    chk("spawn.d_y", int'(d_y), 299);
    chk("spawn.on_plat", int'(on_plat), 1);
    chk("spawn.plat_idx", int'(plat_idx), 3);
    chk("spawn.vel", int'(vel), 0);

    // Ride a rising platform
    for (int k = 0; k < 3; k++) begin
      vp[3] = 299 - k;
      step(1'b1);
      chk("ride_track", int'(d_y), 298 - k);
    end

    // Walk off, accelerate to V_MAX
    d_x = 10'd500;
    step(1'b1);
    chk("walkoff.on_plat", int'(on_plat), 0);
    chk("walkoff.vel", int'(vel), 1);
    chk("walkoff.d_y", int'(d_y), 296);
    exp_dy = 296; exp_v = 1;
    for (int k = 0; k < 7; k++) begin
      step(1'b1);
      exp_dy += exp_v;
      exp_v = (exp_v + 1 > V_MAX) ? V_MAX : exp_v + 1;
      chk("fall_accel.d_y", int'(d_y), exp_dy);
      chk("fall_accel.vel", int'(vel), exp_v);
    end

    // Swept landing at full speed: d_y=323, vel=6, platform top 327
    vp[2] = 327; hp[2] = 480;
    step(1'b1);
    chk("swept.d_y", int'(d_y), 326);
    chk("swept.on_plat", int'(on_plat), 1);
    chk("swept.plat_idx", int'(plat_idx), 2);

    // Two candidates: nearest vpos wins
    vp[5] = 327; hp[5] = 680; vp[1] = 328; hp[1] = 690;
    d_x = 10'd700;
    step(1'b1);
    chk("cand.walkoff", int'(on_plat), 0);
    step(1'b1);
    chk("cand_near.plat_idx", int'(plat_idx), 5);
    chk("cand_near.d_y", int'(d_y), 326);

    // Equal vpos: lowest index wins
    d_x = 10'd850;
    step(1'b1);
    vp[1] = 328; hp[1] = 840; vp[5] = 328; hp[5] = 840;
    step(1'b1);
    chk("cand_tie.plat_idx", int'(plat_idx), 1);
    chk("cand_tie.d_y", int'(d_y), 327);

    // Floor death from d_y=327
    d_x = 10'd300;
    step(1'b1);
    for (int k = 0; k < 80 && !dead; k++) step(1'b1);
    chk("floor.dead", int'(dead), 1);
    chk("floor.d_y", int'(d_y), 474);
    repeat (3) step(1'b1);
    chk("dead_hold.d_y", int'(d_y), 474);

    // Ceiling death while riding
    for (int i = 0; i < NP; i++) begin vp[i] = 400; hp[i] = 1000; end
    vp[3] = 300; hp[3] = 100; d_x = 10'd110;
    do_reset();
    step(1'b0);
    vp[3] = SIZE;
    step(1'b1);
    chk("ceil.dead", int'(dead), 1);
    chk("ceil.d_y", int'(d_y), SIZE - 1);
    chk("ceil.on_plat", int'(on_plat), 0);

    // Freeze during a fall
    vp[3] = 300;
    do_reset();
    step(1'b0);
    d_x = 10'd500;
    repeat (4) step(1'b1);
    terminated = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1'b1);
      chk("frozen.d_y", int'(d_y), 305);
    end
    terminated = 1'b0;
    step(1'b1);
    chk("resume.d_y", int'(d_y), 309);

    // Async reset mid-fall, between edges
    #3;
    do_reset();

    // Randomized play
    for (int n = 0; n < 2500; n++) begin
      r = $urandom % 40;
      if (r == 0) begin
        int i;
        i = $urandom % NP;
        vp[i] = 20 + $urandom % 450;
        hp[i] = 0 + $urandom % 950;
      end else if (r == 1) begin
        int i;
        i = $urandom % NP;
        vp[i] = m_dy + 1 + $urandom % 12;
        if (vp[i] > 1000) vp[i] = 1000;
        hp[i] = int'(d_x) - 60 + $urandom % 80;
        if (hp[i] < 0) hp[i] = 0;
      end
      if (m_mode == 1 && ($urandom % 6 == 0) && vp[m_idx] > 1) vp[m_idx]--;
      if ($urandom % 5 == 0) begin
        int nx;
        nx = int'(d_x) + $urandom_range(30) - 15;
        if (nx < 0) nx = 0;
        if (nx > 1000) nx = 1000;
        d_x = PW'(nx);
      end
      terminated = ($urandom % 12 == 0);
      if ((m_mode == 3 && ($urandom % 4 == 0)) || ($urandom % 400 == 0)) begin
        terminated = 1'b0;
        do_reset();
      end else begin
        step(1'($urandom % 2));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
